// File: rtl/mem_core.sv
// mem_core: single-port synchronous RAM that clears itself after reset.
//
// After reset (or a clr request) the array is swept one location per cycle
// with CLEAR_VAL. Accesses are accepted only once the sweep has finished.
//
// Ports:
//   clk       - single rising-edge clock
//   rst_n     - synchronous active-low reset
//   addr      - access address (ADDR_W bits)
//   read      - read request, sampled on the rising edge
//   write     - write request, sampled on the rising edge
//   data_in   - write data (DATA_W bits)
//   clr       - single-cycle request to re-clear the whole array
//   data_out  - registered read data, holds between accepted reads
//   ready     - high when accesses are accepted (clear sweep finished)
//   err       - one-cycle pulse per rejected or conflicting access
//   wr_count  - saturating count of accepted writes
//   rd_count  - saturating count of accepted reads
module mem_core #(
  parameter int                ADDR_W    = 5,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] CLEAR_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              err,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic in_clear;
  logic clear_we;
  logic do_wr;
  logic do_rd;
  logic err_d;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR: begin
        // clr restarts the sweep, so it also blocks the exit to READY
        if (!clr && (ptr_q == LAST_ADDR)) begin
          state_d = READY;
        end
      end
      READY: begin
        if (clr) begin
          state_d = CLEAR;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ready = (state_q == READY);
  end

  // ---------------------------------------------------------------------------
  // Access decode. Everything is gated by rst_n so that requests held during
  // reset neither touch the array nor raise err.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_clear = (state_q == CLEAR);
    clear_we = rst_n && in_clear && !clr;
    // clr takes priority over any access in the same cycle
    do_wr    = rst_n && ready && !clr && write;
    // a simultaneous read+write keeps the write and drops the read
    do_rd    = rst_n && ready && !clr && read && !write;
    // offences: any request while clearing or alongside clr, or read+write
    err_d    = rst_n && ((read && write) || ((read || write) && (in_clear || clr)));
  end

  // ---------------------------------------------------------------------------
  // Clear pointer. Held at 0 while READY so that entering CLEAR (via clr or
  // reset) always starts the sweep at address 0; wraps from LAST_ADDR to 0
  // on the final sweep cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (clr || (state_q == READY)) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array (no reset: contents are defined by the clear sweep)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[ptr_q] <= CLEAR_VAL;
    end else if (do_wr) begin
      mem[addr] <= data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Read data register: loads only on an accepted read, otherwise holds
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (do_rd) begin
      data_out <= mem[addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Error pulse: registered per cycle, so consecutive offences keep it high
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Access counters: saturate at all-ones, untouched by clr
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_count <= '0;
    end else if (do_wr && (wr_count != '1)) begin
      wr_count <= wr_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_count <= '0;
    end else if (do_rd && (rd_count != '1)) begin
      rd_count <= rd_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_core.sv
// tb_mem_core: scoreboard bench for mem_core.
// The driver applies one set of inputs per cycle at the falling edge,
// advances a behavioural model of the memory and pushes the outputs expected
// after the next rising edge. The monitor pops one entry per cycle, shortly
// after the rising edge, and compares every output.
module tb_mem_core;

  localparam int          AW    = 5;
  localparam int          DW    = 8;
  localparam int          DEPTH = 32;
  localparam logic [7:0]  CV    = 8'h00;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic          read;
  logic          write;
  logic [DW-1:0] data_in;
  logic          clr;
  logic [DW-1:0] data_out;
  logic          ready;
  logic          err;
  logic [15:0]   wr_count;
  logic [15:0]   rd_count;

  mem_core #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .CLEAR_VAL(CV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .read    (read),
    .write   (write),
    .data_in (data_in),
    .clr     (clr),
    .data_out(data_out),
    .ready   (ready),
    .err     (err),
    .wr_count(wr_count),
    .rd_count(rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic        rdy;
    logic [7:0]  dout;
    logic [15:0] wc;
    logic [15:0] rc;
  } exp_t;

  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  // Behavioural model: remaining clear cycles, plain array, integer counters
  logic [7:0] m_mem [DEPTH];
  int         clear_left = DEPTH;
  logic [7:0] m_dout = 8'h00;
  logic       m_err = 1'b0;
  int         m_wc = 0;
  int         m_rc = 0;

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic cyc(input logic r, input logic rd, input logic wr,
                     input int a, input logic [7:0] d, input logic c);
    exp_t e;
    @(negedge clk);
    rst_n   = r;
    read    = rd;
    write   = wr;
    addr    = a[AW-1:0];
    data_in = d;
    clr     = c;
    if (!r) begin
      clear_left = DEPTH;
      m_dout     = 8'h00;
      m_err      = 1'b0;
      m_wc       = 0;
      m_rc       = 0;
    end else if (clear_left > 0) begin
      m_err = rd | wr;
      if (c) begin
        clear_left = DEPTH;
      end else begin
        m_mem[DEPTH - clear_left] = CV;
        clear_left--;
      end
    end else if (c) begin
      m_err      = rd | wr;
      clear_left = DEPTH;
    end else if (wr) begin
      m_mem[a % DEPTH] = d;
      m_wc  = sat_inc(m_wc);
      m_err = rd;
    end else if (rd) begin
      m_dout = m_mem[a % DEPTH];
      m_rc   = sat_inc(m_rc);
      m_err  = 1'b0;
    end else begin
      m_err = 1'b0;
    end
    e.err  = m_err;
    e.rdy  = (clear_left == 0);
    e.dout = m_dout;
    e.wc   = 16'(m_wc);
    e.rc   = 16'(m_rc);
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0);
  endtask

  task automatic rd_at(input int a);
    cyc(1'b1, 1'b1, 1'b0, a, 8'h00, 1'b0);
  endtask

  task automatic wr_at(input int a, input logic [7:0] d);
    cyc(1'b1, 1'b0, 1'b1, a, d, 1'b0);
  endtask

  // Idle until the model leaves the clear sweep; bounded.
  task automatic wait_ready();
    int n = 0;
    while (clear_left > 0 && n < 40) begin
      idle(1);
      n++;
    end
    if (clear_left > 0) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: still clearing after %0d cycles, required ready", n);
    end
  endtask

  // Monitor: one comparison per cycle, just after the rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if (err !== e.err || ready !== e.rdy || data_out !== e.dout ||
            wr_count !== e.wc || rd_count !== e.rc) begin
          errors++;
          $display("FAIL outputs t=%0t: got err=%b ready=%b data_out=%h wr_count=%0d rd_count=%0d, required err=%b ready=%b data_out=%h wr_count=%0d rd_count=%0d",
                   $time, err, ready, data_out, wr_count, rd_count,
                   e.err, e.rdy, e.dout, e.wc, e.rc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    addr    = '0;
    data_in = '0;
    clr     = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = CV;

    // Reset with requests present: no effect, no err
    cyc(1'b0, 1'b1, 1'b1, 3, 8'hEE, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 3, 8'hEE, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 7, 8'h00, 1'b0);

    // Writes to addr 3 during the first 10 clear cycles are rejected
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b1, 3, 8'h77, 1'b0);
    wait_ready();

    // Every location reads CLEAR_VAL; rd_count reaches 32, wr_count stays 0
    for (int i = 0; i < DEPTH; i++) rd_at(i);

    // data = address, then read back
    for (int i = 0; i < DEPTH; i++) wr_at(i, 8'(i));
    for (int i = 0; i < DEPTH; i++) rd_at(i);

    // Read-after-write on the next cycle
    wr_at(9, 8'h3C);
    rd_at(9);

    // Simultaneous read+write: write wins, err pulses, data_out holds
    cyc(1'b1, 1'b1, 1'b1, 5, 8'hA5, 1'b0);
    // back-to-back offences keep err high
    cyc(1'b1, 1'b1, 1'b1, 6, 8'h5A, 1'b0);
    idle(1);
    rd_at(5);
    rd_at(6);

    // Fill, then clr together with a read: clr wins and err pulses
    for (int i = 0; i < DEPTH; i++) wr_at(i, 8'($urandom_range(1, 255)));
    cyc(1'b1, 1'b1, 1'b0, 4, 8'h00, 1'b1);
    idle(31);
    wait_ready();
    for (int i = 0; i < DEPTH; i++) rd_at(i);

    // clr during CLEAR restarts the sweep
    cyc(1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b1);
    idle(10);
    cyc(1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b1);
    wait_ready();
    rd_at(31);

    // Reset on the 15th clear cycle; sweep restarts from 0 after release
    for (int i = 0; i < DEPTH; i++) wr_at(i, 8'($urandom_range(1, 255)));
    cyc(1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b1);
    idle(14);
    cyc(1'b0, 1'b1, 1'b0, 2, 8'h00, 1'b0);
    idle(32);
    for (int i = 0; i < DEPTH; i++) rd_at(i);

    // Randomised traffic with occasional clr and reset
    for (int n = 0; n < 3000; n++) begin
      int unsigned r;
      r = $urandom_range(0, 199);
      cyc((r != 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
          int'($urandom_range(0, DEPTH - 1)), 8'($urandom), (r < 3));
    end

    idle(2);
    @(posedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
